pingpong_ctrl: RTL and testbench

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

---
 rtl/pingpong_ctrl.sv | 126 ++++++++++++
 tb/tb_pingpong_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ctrl.sv
// Ping-pong frame buffer controller: a producer fills one BRAM bank while a consumer drains the other.
// The BRAM itself is external; this block only supplies port enables, addresses and bank selects.
//
// bank state | meaning
// EMPTY      | bank may be written by the producer, never read
// FULL       | bank holds a complete frame, may be read, never written
module pingpong_ctrl #(
   parameter  int BRAM_WIDTH = 12,
   parameter  int FRAME_SIZE = 153600,
   localparam int AW         = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_wvalid,
   input  logic [BRAM_WIDTH-1:0] i_wdata,
   output logic                  o_wready,
   output logic                  o_wportEn,
   output logic                  o_wr,
   output logic [AW-1:0]         o_waddr,
   output logic [BRAM_WIDTH-1:0] o_wdata,
   output logic                  o_wbank,
   input  logic                  i_rreq,
   output logic                  o_rready,
   output logic                  o_rportEn,
   output logic [AW-1:0]         o_raddr,
   output logic                  o_rbank,
   output logic                  o_rvalid,
   output logic                  o_rlast,
   output logic                  o_swap,
   output logic [15:0]           o_drop_cnt
);

   localparam logic [0:0]    BANK_EMPTY = 1'b0;
   localparam logic [0:0]    BANK_FULL  = 1'b1;
   localparam logic [AW-1:0] LAST_ADDR  = AW'(FRAME_SIZE - 1);

   logic [1:0]    bank_q, bank_d;
   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]   drop_q, drop_d;
   logic          rvalid_q, rlast_q, swap_q;

   logic wr_acc, wr_done, wr_drop;
   logic rd_acc, rd_done;

   assign o_wready = (bank_q[wr_bank_q] == BANK_EMPTY);
   assign o_rready = (bank_q[rd_bank_q] == BANK_FULL);

   // Enables are gated by reset so nothing strobes the BRAM while the state is being cleared.
   assign wr_acc  = i_rstn && i_wvalid && o_wready;
   assign wr_drop = i_wvalid && !o_wready;
   assign wr_done = wr_acc && (wr_addr_q == LAST_ADDR);
   assign rd_acc  = i_rstn && i_rreq && o_rready;
   assign rd_done = rd_acc && (rd_addr_q == LAST_ADDR);

   assign o_wportEn  = wr_acc;
   assign o_wr       = wr_acc;
   assign o_waddr    = wr_addr_q;
   assign o_wdata    = i_wdata;
   assign o_wbank    = wr_bank_q;
   assign o_rportEn  = rd_acc;
   assign o_raddr    = rd_addr_q;
   assign o_rbank    = rd_bank_q;
   assign o_rvalid   = rvalid_q;
   assign o_rlast    = rlast_q;
   assign o_swap     = swap_q;
   assign o_drop_cnt = drop_q;

   // Writer and reader always own different banks, so both updates can apply in one cycle.
   always_comb begin
      bank_d    = bank_q;
      wr_bank_d = wr_bank_q;
      wr_addr_d = wr_addr_q;
      rd_bank_d = rd_bank_q;
      rd_addr_d = rd_addr_q;
      drop_d    = drop_q;
      if (wr_acc) begin
         if (wr_done) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_addr_d         = '0;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_addr_d = wr_addr_q + AW'(1);
         end
      end
      if (rd_acc) begin
         if (rd_done) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_addr_d         = '0;
            rd_bank_d         = ~rd_bank_q;
         end else begin
            rd_addr_d = rd_addr_q + AW'(1);
         end
      end
      if (wr_drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         bank_q    <= {BANK_EMPTY, BANK_EMPTY};
         wr_bank_q <= 1'b0;
         wr_addr_q <= '0;
         rd_bank_q <= 1'b0;
         rd_addr_q <= '0;
         drop_q    <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         swap_q    <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         wr_bank_q <= wr_bank_d;
         wr_addr_q <= wr_addr_d;
         rd_bank_q <= rd_bank_d;
         rd_addr_q <= rd_addr_d;
         drop_q    <= drop_d;
         rvalid_q  <= rd_acc;
         rlast_q   <= rd_done;
         swap_q    <= wr_done;
      end
   end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with FRAME_SIZE=4; expected writes/reads are queued when
// driven and popped when the DUT strobes its BRAM ports.
module tb_pingpong_ctrl;

   localparam int W  = 12;
   localparam int FS = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          i_rstn, i_wvalid, i_rreq;
   logic [W-1:0]  i_wdata;
   logic          o_wready, o_wportEn, o_wr, o_wbank;
   logic [AW-1:0] o_waddr, o_raddr;
   logic [W-1:0]  o_wdata;
   logic          o_rready, o_rportEn, o_rbank, o_rvalid, o_rlast, o_swap;
   logic [15:0]   o_drop_cnt;

   always #5 clk = ~clk;

   pingpong_ctrl #(.BRAM_WIDTH(W), .FRAME_SIZE(FS)) dut (
      .i_clk      (clk),
      .i_rstn     (i_rstn),
      .i_wvalid   (i_wvalid),
      .i_wdata    (i_wdata),
      .o_wready   (o_wready),
      .o_wportEn  (o_wportEn),
      .o_wr       (o_wr),
      .o_waddr    (o_waddr),
      .o_wdata    (o_wdata),
      .o_wbank    (o_wbank),
      .i_rreq     (i_rreq),
      .o_rready   (o_rready),
      .o_rportEn  (o_rportEn),
      .o_raddr    (o_raddr),
      .o_rbank    (o_rbank),
      .o_rvalid   (o_rvalid),
      .o_rlast    (o_rlast),
      .o_swap     (o_swap),
      .o_drop_cnt (o_drop_cnt)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [W+AW:0] wq[$];
   logic [AW:0]   rq[$];
   logic          rvq[$];

   logic          m_wbank, m_rbank;
   logic [AW-1:0] m_waddr, m_raddr;
   logic          swap_prev, rv_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_wbank   = 1'b0;
      m_rbank   = 1'b0;
      m_waddr   = '0;
      m_raddr   = '0;
      swap_prev = 1'b0;
      rv_prev   = 1'b0;
      wq.delete();
      rq.delete();
      rvq.delete();
   endtask

   // One clock of stimulus; exp_w/exp_r say whether the write/read should be accepted.
   task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr,
                       input logic exp_w, input logic exp_r);
      logic [W+AW:0] we;
      logic [AW:0]   re;
      logic          rl;
      logic          swap_now, rv_now;
      @(negedge clk);
      i_wvalid = wv;
      i_wdata  = wd;
      i_rreq   = rr;
      swap_now = 1'b0;
      rv_now   = 1'b0;
      if (exp_w) begin
         wq.push_back({m_wbank, m_waddr, wd});
         if (m_waddr == AW'(FS - 1)) begin
            m_waddr  = '0;
            m_wbank  = ~m_wbank;
            swap_now = 1'b1;
         end else begin
            m_waddr = m_waddr + AW'(1);
         end
      end
      if (exp_r) begin
         rq.push_back({m_rbank, m_raddr});
         rvq.push_back(m_raddr == AW'(FS - 1));
         rv_now = 1'b1;
         if (m_raddr == AW'(FS - 1)) begin
            m_raddr = '0;
            m_rbank = ~m_rbank;
         end else begin
            m_raddr = m_raddr + AW'(1);
         end
      end
      #1;
      chk("o_swap", o_swap, swap_prev);
      chk("o_rvalid", o_rvalid, rv_prev);
      if (o_rvalid === 1'b1 && rvq.size() > 0) begin
         rl = rvq.pop_front();
         chk("o_rlast", o_rlast, rl);
      end
      chk("o_wr", o_wr, exp_w);
      chk("o_wportEn", o_wportEn, exp_w);
      if (o_wr === 1'b1 && wq.size() > 0) begin
         we = wq.pop_front();
         chk("write bank/addr/data", {o_wbank, o_waddr, o_wdata}, we);
      end
      chk("o_rportEn", o_rportEn, exp_r);
      if (o_rportEn === 1'b1 && rq.size() > 0) begin
         re = rq.pop_front();
         chk("read bank/addr", {o_rbank, o_raddr}, re);
      end
      swap_prev = swap_now;
      rv_prev   = rv_now;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rstn   = 1'b0;
      i_wvalid = 1'b1;
      i_rreq   = 1'b1;
      i_wdata  = 12'hABC;
      #1;
      chk("rst o_wr", o_wr, 0);
      chk("rst o_wportEn", o_wportEn, 0);
      chk("rst o_rportEn", o_rportEn, 0);
      @(negedge clk);
      #1;
      chk("rst o_rvalid", o_rvalid, 0);
      chk("rst o_rlast", o_rlast, 0);
      chk("rst o_swap", o_swap, 0);
      chk("rst o_drop_cnt", o_drop_cnt, 0);
      chk("rst o_wready", o_wready, 1);
      chk("rst o_rready", o_rready, 0);
      chk("rst bank/addr", {o_wbank, o_waddr, o_rbank, o_raddr}, 0);
      chk("rst o_wr held", o_wr, 0);
      i_rstn   = 1'b1;
      i_wvalid = 1'b0;
      i_rreq   = 1'b0;
      i_wdata  = '0;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rstn   = 1'b0;
      i_wvalid = 1'b0;
      i_rreq   = 1'b0;
      i_wdata  = '0;
      model_reset();

      do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Fill bank 0
      for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("wbank after fill0", o_wbank, 1);
      chk("rready after fill0", o_rready, 1);
      chk("wready after fill0", o_wready, 1);
      chk("rbank after fill0", o_rbank, 0);

      // Fill bank 1, then a rejected word
      for (int i = 5; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("wready both full", o_wready, 0);
      step(1'b1, W'(9), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("drop_cnt one", o_drop_cnt, 1);

      // Drain bank 0; writer must stay blocked until the release lands
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b1);
         chk("wready during drain", o_wready, 0);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("wready after release", o_wready, 1);
      chk("wbank after release", o_wbank, 0);

      // Concurrent fill/drain, twice, so completions coincide on both bank orientations
      for (int i = 0; i < 4; i++) step(1'b1, W'(10 + i), 1'b1, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("wbank after conc1", o_wbank, 1);
      chk("rbank after conc1", o_rbank, 0);
      for (int i = 0; i < 4; i++) step(1'b1, W'(20 + i), 1'b1, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rbank after conc2", o_rbank, 1);
      chk("wbank after conc2", o_wbank, 0);
      chk("rready after conc2", o_rready, 1);
      chk("wready after conc2", o_wready, 1);
      chk("drop_cnt unchanged", o_drop_cnt, 1);

      // Drain bank 1, then request reads with both banks empty
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rready both empty", o_rready, 0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Full frame plus a partial frame, then reset discards both
      for (int i = 1; i <= 4; i++) step(1'b1, W'(30 + i), 1'b0, 1'b1, 1'b0);
      step(1'b1, W'(35), 1'b0, 1'b1, 1'b0);
      step(1'b1, W'(36), 1'b0, 1'b1, 1'b0);
      do_reset();
      step(1'b1, W'(40), 1'b0, 1'b1, 1'b0);
      step(1'b1, W'(41), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rready after reset", o_rready, 0);
      chk("waddr after reset writes", o_waddr, 2);
      chk("drop_cnt after reset", o_drop_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
